// File: rtl/lvds_outbuffer_ser_ice1f.sv
// lvds_outbuffer_ser_ice1f: MSB-first LVDS serializer with valid/ready input and cbit/vddio gated enable.
module lvds_outbuffer_ser_ice1f #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:2]       cbit,
  input  logic             vddio,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out_padp,
  output logic             out_padn,
  output logic             tx_busy,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {DISABLED, IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             en, last;
  assign en   = ~cbit[2] & ~cbit[3] & cbit[4] & vddio;
  assign last = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign data_ready = (state_q == IDLE) || last;
  assign tx_busy    = state_q == SHIFT;
  assign word_done  = last;
  // pads are decoded only from registered state, so they never glitch on input changes
  assign out_padp   = tx_busy & sreg_q[WIDTH-1];
  assign out_padn   = (state_q == IDLE) | (tx_busy & ~sreg_q[WIDTH-1]);
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = DISABLED;
      sreg_d  = '0;
      cnt_d   = '0;
    end else if (state_q == DISABLED) begin
      state_d = IDLE;
    end else if (data_ready && data_valid) begin
      state_d = SHIFT;
      sreg_d  = data_in;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      state_d = last ? IDLE : SHIFT;
      sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
      cnt_d   = last ? '0 : cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISABLED;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_lvds_outbuffer_ser_ice1f.sv
// tb_lvds_outbuffer_ser_ice1f: directed plus random stimulus against a bit-queue reference model.
module tb_lvds_outbuffer_ser_ice1f;
  localparam int WIDTH = 8;
  logic             clk = 0;
  logic             rst;
  logic [4:2]       cbit;
  logic             vddio;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready, out_padp, out_padn, tx_busy, word_done;
  int               total = 0;
  int               bad = 0;
  bit               on;
  bit               q[$];
  lvds_outbuffer_ser_ice1f #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .cbit(cbit), .vddio(vddio), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .out_padp(out_padp),
    .out_padn(out_padn), .tx_busy(tx_busy), .word_done(word_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic chk_all(input string tag, input logic ep, input logic en, input logic r, input logic b, input logic d);
    chk({tag, ".padp"}, out_padp, ep);
    chk({tag, ".padn"}, out_padn, en);
    chk({tag, ".ready"}, data_ready, r);
    chk({tag, ".busy"}, tx_busy, b);
    chk({tag, ".done"}, word_done, d);
  endtask
  // Model: "on" means enabled and past the wake-up edge; q holds the bits of the
  // current word still to appear on the pad, head = bit on the pad now.
  task automatic cyc(input string tag);
    logic ep, en, r, b, d, acc;
    if (!on) {ep, en, r, b, d} = 5'b00000;
    else if (q.size() == 0) {ep, en, r, b, d} = 5'b01100;
    else begin
      ep = q[0]; en = ~q[0]; b = 1; r = q.size() == 1; d = r;
    end
    chk_all(tag, ep, en, r, b, d);
    @(posedge clk);
    if (!(cbit == 3'b100 && vddio)) begin
      on = 0;
      q.delete();
    end else if (!on) on = 1;
    else begin
      acc = r && data_valid;
      if (q.size() != 0) void'(q.pop_front());
      if (acc) for (int i = WIDTH - 1; i >= 0; i--) q.push_back(data_in[i]);
    end
    #1;
  endtask
  initial begin
    rst = 1; cbit = 3'b000; vddio = 0; data_in = '0; data_valid = 0;
    on = 0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 0;
    cbit = 3'b100; vddio = 1;
    cyc("wake");
    cyc("idle");
    data_in = 8'hA5; data_valid = 1;
    cyc("a5_acc");
    data_valid = 0; data_in = 8'($urandom);
    repeat (9) cyc("a5");
    data_in = 8'hFF; data_valid = 1;
    cyc("ff_acc");
    data_in = 8'h00;
    repeat (8) cyc("stream");
    data_valid = 0;
    repeat (9) cyc("stream_tail");
    data_in = 8'hC3; data_valid = 1;
    cyc("c3_acc");
    data_valid = 0;
    repeat (3) cyc("c3");
    cbit = 3'b110;
    cyc("c3_abort");
    cyc("c3_off");
    cbit = 3'b100;
    cyc("c3_wake");
    data_in = 8'h3C; data_valid = 1;
    cyc("3c_acc");
    data_valid = 0;
    repeat (9) cyc("3c");
    vddio = 0;
    cyc("vdd_drop");
    data_valid = 1; data_in = 8'h5A;
    repeat (3) cyc("vdd_off");
    vddio = 1;
    cyc("vdd_wake");
    cyc("5a_acc");
    data_valid = 0;
    repeat (9) cyc("5a");
    data_in = 8'($urandom); data_valid = 1;
    cyc("rst_acc");
    data_valid = 0;
    cyc("rst_sh0");
    cyc("rst_sh1");
    #2 rst = 1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    rst = 0;
    on = 0; q.delete();
    for (int n = 0; n < 400; n++) begin
      cbit = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b100;
      vddio = $urandom_range(0, 19) != 0;
      data_valid = 1'($urandom);
      data_in = 8'($urandom);
      cyc("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lvds_outbuffer_ser_ice1f.md
Name: lvds_outbuffer_ser_ice1f

Overview:
Differential LVDS output-side counterpart for ice1f I/O tiles. Accepts parallel words over a valid/ready handshake and serializes them MSB-first onto a complementary pad pair, one bit per clock. Output enable uses the same configuration-bit decode as the LVDS input buffer, so one cbit[4:2] setting enables both directions of an LVDS pair. Sits between fabric TX logic and the I/O pad cell.

Parameters:
WIDTH, 8, bits per serialized word (legal 2..16)

Ports:
clk  input  1  serializer bit clock
rst  input  1  asynchronous reset, active-high
cbit  input  3 [4:2]  config bits; lvdsen = ~cbit[2] & ~cbit[3] & cbit[4]
vddio  input  1  I/O supply-good; 0 forces pads low and disables the block
data_in  input  WIDTH  parallel word to transmit
data_valid  input  1  data_in valid
data_ready  output  1  block accepts data_in on this edge if data_valid
out_padp  output  1  true pad
out_padn  output  1  complement pad
tx_busy  output  1  a word is currently being shifted
word_done  output  1  one-cycle pulse coinciding with the last bit of a word

Behaviour:
- en = lvdsen & vddio, sampled combinationally every cycle.
- Reset (async, rst=1): state=DISABLED, shift reg=0, bit counter=0; out_padp=0, out_padn=0, data_ready=0, tx_busy=0, word_done=0. All outputs registered.
- States: DISABLED, IDLE, SHIFT.
- DISABLED: pads 0/0 (both low, electrically off). data_ready=0. en=1 -> IDLE next edge.
- IDLE: pads 0/1 (differential zero line state). data_ready=1. data_valid=1 at an edge -> load data_in, counter=0, go SHIFT; out_padp=data_in[WIDTH-1] visible after that same edge.
- SHIFT: out_padp=current bit, out_padn=~out_padp. Counter increments each edge; bits WIDTH-1 down to 0 on consecutive cycles, exactly WIDTH cycles per word.
- data_ready=1 in SHIFT only while counter==WIDTH-1 (last bit). Accept there -> reload, next word's MSB follows with no gap. No accept -> IDLE, line returns to 0/1.
- word_done=1 exactly during the counter==WIDTH-1 cycle; tx_busy=1 throughout SHIFT.
- Latency: accept edge to MSB on pad = 0 cycles after that edge (registered). Word throughput = 1 per WIDTH cycles when streaming.
- en falling in any state: next edge -> DISABLED, in-flight word discarded (not resumed), word_done not pulsed, pads 0/0, counter cleared.
- data_valid while data_ready=0: ignored; the source must hold it.
- data_in changes after acceptance: no effect on the word in flight.
- rst asserted mid-word: immediate return to reset values; word lost.
- out_padn is always ~out_padp except in DISABLED/reset (both 0).

Test Plan:
- Reset then cbit=3'b100, vddio=1 -> DISABLED for 1 edge, then IDLE: pads 0/1, data_ready=1.
- WIDTH=8, send 0xA5 once -> out_padp 1,0,1,0,0,1,0,1 on 8 consecutive cycles, out_padn complementary, word_done high on the 8th, then pads 0/1.
- Stream 0xFF then 0x00 with data_valid held -> 16 contiguous bits (8x1 then 8x0), data_ready high only in bit-7 cycles, two word_done pulses 8 cycles apart.
- Mid-word (after 3 bits of 0xC3) set cbit[3]=1 -> next edge pads 0/0, tx_busy=0, no word_done. Restore cbit=3'b100 -> IDLE after 1 edge, new word sent intact.
- vddio=0 during IDLE -> DISABLED, pads 0/0, data_ready=0. data_valid ignored until vddio=1.
- rst pulse asynchronously in SHIFT (between edges) -> all outputs 0 immediately, without waiting for a clock edge.
